// File: rtl/act_pipe_lanes_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
//   Shared types and reset constants for the multi-lane activation stage.
//   act_mode_t : lane function select (identity, ReLU, leaky ReLU, clamped ReLU)
//   RST_MODE   : mode loaded at reset (ReLU, matching the old single-port unit)
//   RST_SHIFT  : leaky slope shift loaded at reset
// ---------------------------------------------------------------------------
package act_pkg;

  typedef enum logic [1:0] {
    ACT_ID    = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_t;

  localparam act_mode_t  RST_MODE  = ACT_RELU;
  localparam logic [3:0] RST_SHIFT = 4'd3;

endpackage

// File: rtl/act_pipe_lanes_if.sv
// ---------------------------------------------------------------------------
// act_pipe_lanes_if
//   Valid/ready beat stream carrying LANES packed DATA_W elements.
//   valid : beat valid (producer)
//   ready : beat accepted when valid & ready (consumer)
//   data  : lane i = data[i*DATA_W +: DATA_W]
//   master modport = producer side, slave modport = consumer side.
// ---------------------------------------------------------------------------
interface act_pipe_lanes_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic                      valid;
  logic                      ready;
  logic [LANES*DATA_W-1:0]   data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/act_pipe_lanes_lane.sv
// ---------------------------------------------------------------------------
// act_lane
//   Combinational activation for one signed element.
//   x       : input element (signed)
//   mode    : function select
//   shift   : leaky slope, negative x -> x >>> shift
//   clip    : clamp ceiling (non-negative, enforced by the config register)
//   y       : activated element, same width as x
//   clipped : x exceeded the ceiling in clamp mode
// ---------------------------------------------------------------------------
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x,
  input  act_mode_t                mode,
  input  logic        [3:0]        shift,
  input  logic signed [DATA_W-1:0] clip,
  output logic signed [DATA_W-1:0] y,
  output logic                     clipped
);

  logic neg;
  logic over;

  assign neg  = x[DATA_W-1];
  assign over = (x > clip);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    y       = x;
    clipped = 1'b0;
    case (mode)
      ACT_ID:    y = x;
      ACT_RELU:  y = neg ? '0 : x;
      // Arithmetic shift keeps the sign, so the most negative value stays negative.
      ACT_LEAKY: y = neg ? (x >>> shift) : x;
      ACT_CLAMP: begin
        if (neg) begin
          y = '0;
        end else if (over) begin
          y       = clip;
          clipped = 1'b1;
        end else begin
          y = x;
        end
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe_lanes.sv
// ---------------------------------------------------------------------------
// act_pipe_lanes
//   Multi-lane activation stage between the MAC accumulators and the next
//   layer's operand buffer. Two-stage pipeline (retime, then function) with
//   valid/ready flow control and a saturating clip counter.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_we         : load cfg_mode/cfg_shift/cfg_clip into the config regs
//   cfg_mode       : 0 identity, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU
//   cfg_shift      : leaky slope shift
//   cfg_clip       : clamp ceiling (MSB ignored)
//   in_bus         : input beat stream (slave)
//   out_bus        : output beat stream (master)
//   stat_clr       : clear the clip counter (wins over an increment)
//   stat_clip_cnt  : lanes clamped at the ceiling, saturating
// ---------------------------------------------------------------------------
module act_pipe_lanes
  import act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_mode,
  input  logic [3:0]          cfg_shift,
  input  logic [DATA_W-1:0]   cfg_clip,
  act_pipe_lanes_if.slave     in_bus,
  act_pipe_lanes_if.master    out_bus,
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    stat_clip_cnt
);

  localparam int                BUS_W    = LANES * DATA_W;
  localparam int                POP_W    = $clog2(LANES + 1);
  localparam logic [DATA_W-1:0] CLIP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  // Config registers
  act_mode_t          mode_q;
  logic [3:0]         shift_q;
  logic [DATA_W-1:0]  clip_q;

  // Stage 1: retimed beat plus the config it was accepted under
  logic               s1_v;
  logic [BUS_W-1:0]   s1_data;
  act_mode_t          s1_mode;
  logic [3:0]         s1_shift;
  logic [DATA_W-1:0]  s1_clip;

  // Stage 2: activated beat
  logic               s2_v;
  logic [BUS_W-1:0]   s2_data;

  logic               adv2;
  logic               accept;
  logic [BUS_W-1:0]   lane_y;
  logic [LANES-1:0]   lane_clipped;
  logic [POP_W-1:0]   n_clipped;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   cnt_q;

  // Stage 2 takes a new beat whenever it is empty or draining this cycle;
  // stage 1 can take one whenever it is empty or moving forward.
  assign adv2         = s1_v & (~s2_v | out_bus.ready);
  assign in_bus.ready = ~s1_v | adv2;
  assign accept       = in_bus.valid & in_bus.ready;

  assign out_bus.valid = s2_v;
  assign out_bus.data  = s2_data;
  assign stat_clip_cnt = cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes a same-edge cfg_we invisible
  // to the beat being accepted on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= RST_MODE;
      shift_q <= RST_SHIFT;
      clip_q  <= CLIP_MAX;
    end else if (cfg_we) begin
      mode_q  <= act_mode_t'(cfg_mode);
      shift_q <= cfg_shift;
      // Ceiling is kept non-negative so the clamp never outputs a negative value.
      clip_q  <= cfg_clip & CLIP_MAX;
    end
  end

  // NOTE: only the valid flags are reset; the stage-1 payload is qualified by
  // s1_v and is left without reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v <= 1'b1;
    end else if (adv2) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data  <= in_bus.data;
      s1_mode  <= mode_q;
      s1_shift <= shift_q;
      s1_clip  <= clip_q;
    end
  end

  // Output is held while stalled; a handshake plus a new beat reloads with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
    end else if (adv2) begin
      s2_v    <= 1'b1;
      s2_data <= lane_y;
    end else if (out_bus.ready) begin
      s2_v    <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.DATA_W(DATA_W)) u_lane (
      .x       (s1_data[i*DATA_W +: DATA_W]),
      .mode    (s1_mode),
      .shift   (s1_shift),
      .clip    (s1_clip),
      .y       (lane_y[i*DATA_W +: DATA_W]),
      .clipped (lane_clipped[i])
    );
  end

  always_comb begin
    n_clipped = '0;
    for (int i = 0; i < LANES; i++) begin
      n_clipped = n_clipped + POP_W'(lane_clipped[i]);
    end
  end

  // One extra bit catches the carry out so the counter saturates instead of wrapping.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(n_clipped);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      cnt_q <= '0;
    end else if (adv2 && s1_mode == ACT_CLAMP) begin
      cnt_q <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_act_pipe_lanes.sv
module tb_act_pipe_lanes;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_shift;
  logic [15:0] cfg_clip;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        stat_clr;
  logic [15:0] stat_clip_cnt;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;

  act_pipe_lanes_if #(.DATA_W(16), .LANES(4)) in_bus ();
  act_pipe_lanes_if #(.DATA_W(16), .LANES(4)) out_bus ();

  assign in_bus.valid  = in_valid;
  assign in_bus.data   = in_data;
  assign in_ready      = in_bus.ready;
  assign out_bus.ready = out_ready;
  assign out_valid     = out_bus.valid;
  assign out_data      = out_bus.data;

  act_pipe_lanes #(.DATA_W(16), .LANES(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_mode      (cfg_mode),
    .cfg_shift     (cfg_shift),
    .cfg_clip      (cfg_clip),
    .in_bus        (in_bus),
    .out_bus       (out_bus),
    .stat_clr      (stat_clr),
    .stat_clip_cnt (stat_clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        do_cfg;
    logic [1:0]  mode;
    logic [3:0]  shift;
    logic [15:0] clip;
    logic [63:0] din;
    logic [63:0] dout;
    logic [15:0] cnt;   // expected running clip count after the beat
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane 0 is the first argument (least significant slice).
  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [3:0] s, input logic [15:0] c);
    cfg_we    = 1'b1;
    cfg_mode  = m;
    cfg_shift = s;
    cfg_clip  = c;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.do_cfg) set_cfg(v.mode, v.shift, v.clip);
    in_valid = 1'b1;
    in_data  = v.din;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, v.dout);
    check({tag, "_cnt"}, 64'(stat_clip_cnt), 64'(v.cnt));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q[$];
    logic [63:0] exp_d;
    logic [63:0] held;
    logic        hold;
    int          sent;
    int          got;
    int          seen_valid;

    vecs[0] = '{1'b0, 2'd1, 4'd3, 16'h7fff, pk(-5, 0, 7, -32768),     pk(0, 0, 7, 0),           16'd0};
    vecs[1] = '{1'b1, 2'd2, 4'd2, 16'h7fff, pk(-8, -1, 12, -32768),   pk(-2, -1, 12, -8192),    16'd0};
    vecs[2] = '{1'b1, 2'd3, 4'd0, 16'd100,  pk(150, 100, -3, 101),    pk(100, 100, 0, 100),     16'd2};
    vecs[3] = '{1'b1, 2'd0, 4'd0, 16'd0,    pk(-4, 32767, -32768, 1), pk(-4, 32767, -32768, 1), 16'd2};
    vecs[4] = '{1'b1, 2'd2, 4'd0, 16'd0,    pk(-7, 5, -32768, 0),     pk(-7, 5, -32768, 0),     16'd2};
    vecs[5] = '{1'b1, 2'd2, 4'd15, 16'd0,   pk(-32768, -1, -2, 3),    pk(-1, -1, -1, 3),        16'd2};
    vecs[6] = '{1'b1, 2'd3, 4'd0, 16'h8005, pk(6, 5, -1, 32767),      pk(5, 5, 0, 5),           16'd4};
    vecs[7] = '{1'b1, 2'd3, 4'd0, 16'd0,    pk(0, 1, -1, 2),          pk(0, 0, 0, 0),           16'd6};

    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_mode  = 2'd0;
    cfg_shift = 4'd0;
    cfg_clip  = 16'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cnt", 64'(stat_clip_cnt), 64'd0);
    check("rst_out_data", out_data, 64'd0);

    // Table-driven lane function vectors (vec0 relies on the reset mode)
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: 8 beats, output stalled for 3 cycles mid-stream
    set_cfg(2'd0, 4'd0, 16'd0);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = pk(100 + sent, -sent, 7 * sent, 30000 - sent);
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      check("bp_out_valid", 64'(out_valid), 64'(q.size() > 0 && cyc > 1 ? 1 : out_valid));
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 64'hdead;
        check("bp_order", out_data, exp_d);
        got++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      step();
      if (hold) begin
        check("bp_stable_data", out_data, held);
        check("bp_stable_valid", 64'(out_valid), 64'd1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd8);
    check("bp_leftover", 64'(q.size()), 64'd0);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Config race: mode change on the same edge as an accept
    set_cfg(2'd1, 4'd3, 16'h7fff);
    cfg_we   = 1'b1;
    cfg_mode = 2'd0;
    in_valid = 1'b1;
    in_data  = pk(-4, -4, -4, -4);
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    check("race_old_cfg_valid", 64'(out_valid), 64'd1);
    check("race_old_cfg_data", out_data, 64'd0);
    step();
    check("race_new_cfg_valid", 64'(out_valid), 64'd1);
    check("race_new_cfg_data", out_data, pk(-4, -4, -4, -4));
    step();

    // stat_clr alone, then stat_clr against a simultaneous increment
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_cnt", 64'(stat_clip_cnt), 64'd0);
    set_cfg(2'd3, 4'd0, 16'd0);
    in_valid = 1'b1;
    in_data  = pk(1, 1, 1, 1);
    step();
    in_valid = 1'b0;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_wins_data", out_data, 64'd0);
    check("clr_wins_cnt", 64'(stat_clip_cnt), 64'd0);
    step();

    // Counter accumulation and saturation at full throughput
    in_valid = 1'b1;
    in_data  = pk(1, 1, 1, 1);
    repeat (100) step();
    in_valid = 1'b0;
    step();
    step();
    check("cnt_accum", 64'(stat_clip_cnt), 64'd400);
    in_valid = 1'b1;
    repeat (16300) step();
    in_valid = 1'b0;
    step();
    step();
    check("cnt_saturate", 64'(stat_clip_cnt), 64'hffff);

    // Reset with both stages full drops everything and restores defaults
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(9, 9, 9, 9);
    step();
    step();
    check("midrst_full_in_ready", 64'(in_ready), 64'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_cnt", 64'(stat_clip_cnt), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    seen_valid = 0;
    repeat (4) begin
      step();
      if (out_valid) seen_valid++;
    end
    check("midrst_no_ghost", 64'(seen_valid), 64'd0);
    run_vec(vecs[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
